atctlc2axi500_ostd_tracker: RTL and testbench
=============================================

Name: atctlc2axi500_ostd_tracker

Overview:
Outstanding-transaction slot allocator for the TLC-to-AXI bridge. It keeps a free/busy bitmap of N slots. Each cycle it offers the lowest free slot as a binary index and stores a request tag per slot. On response it releases the slot and returns the stored tag. Binary slot indices are expanded to set/clear masks through the existing atctlc2axi500_bin2onehot converter, and the same indices drive the AXI ID and response-routing logic downstream.

Parameters:
N, 8, number of outstanding slots (2..64)
TAG_W, 8, width of per-slot tag (source ID / beat info)
W, $clog2(N), localparam, slot index width

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
cfg_max_ostd  input  W+1  outstanding limit; 0 means N, values >N treated as N
alloc_valid  input  1  requester wants a slot
alloc_tag  input  TAG_W  tag stored on allocation
alloc_ready  output  1  a slot is available under the limit
alloc_idx  output  W  binary index of granted slot (lowest free)
rel_valid  input  1  release a slot (always accepted)
rel_idx  input  W  binary index of slot to release
rel_tag  output  TAG_W  tag stored in rel_idx (combinational read)
busy_mask  output  N  registered busy bitmap
ostd_cnt  output  W+1  registered count of busy slots
empty  output  1  ostd_cnt == 0
full  output  1  ostd_cnt == effective limit
err_rel_idle  output  1  sticky: release of a non-busy slot or rel_idx >= N

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - busy_mask=0, ostd_cnt=0, err_rel_idle=0, tag storage=0.
  - Consequently empty=1, full=0, alloc_ready=1 whenever the effective limit >0.
- Effective limit: lim = (cfg_max_ostd==0 || cfg_max_ostd>N) ? N : cfg_max_ostd.
- alloc_ready = (ostd_cnt < lim). Combinational from registers only; no dependency on alloc_valid or rel_valid.
- alloc_idx = lowest-index zero bit of busy_mask. It is combinational and stable while busy_mask is stable. When no slot is free, the value is don't-care (drive 0).
- Allocation fires on alloc_valid & alloc_ready. At the next edge:
  - busy_mask |= onehot(alloc_idx);
  - tag[alloc_idx] <= alloc_tag.
  - Latency: the slot is visible as busy 1 cycle after the handshake.
- Release fires on rel_valid (no ready). At the next edge: busy_mask &= ~onehot(rel_idx).
  - rel_tag reflects storage at rel_idx in the same cycle.
  - Tags are not cleared on release.
- Simultaneous alloc and release in the same cycle:
  - Both take effect and ostd_cnt is unchanged.
  - alloc_idx is chosen from the pre-release mask, so a slot being released is never re-granted in that same cycle.
  - If the released slot equals alloc_idx, that is an illegal release and sets err_rel_idle. Allocation still wins and the bit stays set.
- ostd_cnt: +1 on alloc only, -1 on legal release only, unchanged on both or neither. It never wraps; an illegal release does not decrement.
- err_rel_idle: set when rel_valid & (rel_idx>=N | ~busy_mask[rel_idx]). Cleared only by reset. An illegal release leaves the mask unchanged.
- Limit lowered below ostd_cnt at runtime: alloc_ready=0 until releases bring ostd_cnt below lim. full compares with ==, so full=0 in this over-limit case.
- Reset mid-operation: all slots are freed immediately and tags are lost. Upstream must discard in-flight responses.

Decomposition:
- Shared package atctlc2axi500_pkg:
  - slot index typedef sized by W;
  - TAG_W default;
  - count width W+1.
- Sub-modules: two instances of atctlc2axi500_bin2onehot #(.N(N)), one for alloc_idx → set mask and one for rel_idx → clear mask.
- Lowest-free priority encoder: an in-module function. No further sub-module.

Test Plan:
- Reset, then 8 consecutive allocs with tags 0x10..0x17, N=8, cfg_max_ostd=0 -> alloc_idx 0..7 in order; after the last, ostd_cnt=8, full=1, alloc_ready=0, busy_mask=0xFF.
- From full, release idx 3 -> rel_tag=0x13 in same cycle; next cycle busy_mask=0xF7, ostd_cnt=7, alloc_ready=1, alloc_idx=3.
- busy_mask=0x0F; same cycle alloc (tag 0xAA) and release idx 1 -> granted idx 4, next busy_mask=0x1D, ostd_cnt stays 4.
- cfg_max_ostd=2 -> after 2 allocs, alloc_ready=0 and full=1. Set cfg_max_ostd=1 -> full=0, alloc_ready=0. After 2 releases -> alloc_ready=1.
- Release idx 5 when busy_mask=0x01 -> err_rel_idle=1 (sticky), busy_mask=0x01, ostd_cnt=1 unchanged.
- Assert aresetn=0 mid-traffic with busy_mask=0x3C -> outputs clear immediately (busy_mask=0, empty=1); after deassert, first alloc_idx=0.

Source files
------------

// File: rtl/atctlc2axi500_pkg.sv
// Shared types and defaults for the TLC-to-AXI bridge outstanding-transaction tracking.
package atctlc2axi500_pkg;

    localparam int OSTD_N_DEF     = 8;
    localparam int OSTD_TAG_W_DEF = 8;
    localparam int OSTD_W_DEF     = $clog2(OSTD_N_DEF);
    localparam int OSTD_CNT_W_DEF = OSTD_W_DEF + 1;

    typedef logic [OSTD_W_DEF-1:0]     slot_idx_t;
    typedef logic [OSTD_CNT_W_DEF-1:0] ostd_cnt_t;
    typedef logic [OSTD_TAG_W_DEF-1:0] slot_tag_t;

endpackage

// File: rtl/atctlc2axi500_bin2onehot.sv
// Binary index to one-hot mask converter; indices >= N produce an all-zero mask.
module atctlc2axi500_bin2onehot #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [W-1:0] bin_i,
    output logic [N-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (bin_i == W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atctlc2axi500_ostd_tracker.sv
// Outstanding-transaction slot allocator: grants the lowest free slot, stores a tag per slot
// and returns it on release.
module atctlc2axi500_ostd_tracker
    import atctlc2axi500_pkg::*;
#(
    parameter int N = OSTD_N_DEF,
    parameter int TAG_W = OSTD_TAG_W_DEF,
    localparam int W = $clog2(N)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [W:0]       cfg_max_ostd,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_ready,
    output logic [W-1:0]     alloc_idx,
    input  logic             rel_valid,
    input  logic [W-1:0]     rel_idx,
    output logic [TAG_W-1:0] rel_tag,
    output logic [N-1:0]     busy_mask,
    output logic [W:0]       ostd_cnt,
    output logic             empty,
    output logic             full,
    output logic             err_rel_idle
);

    typedef logic [W:0] cnt_t;

    function automatic logic [W-1:0] lowest_free(input logic [N-1:0] busy);
        lowest_free = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                lowest_free = W'(i);
            end
        end
    endfunction

    logic [N-1:0]     busy_q, busy_d;
    cnt_t             cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];

    logic [N-1:0] set_mask, clr_mask;
    cnt_t         lim;
    logic         alloc_fire, rel_hit, rel_legal;

    atctlc2axi500_bin2onehot #(.N(N)) u_set_dec (
        .bin_i    (alloc_idx),
        .onehot_o (set_mask)
    );

    atctlc2axi500_bin2onehot #(.N(N)) u_clr_dec (
        .bin_i    (rel_idx),
        .onehot_o (clr_mask)
    );

    always_comb begin
        lim = ((cfg_max_ostd == '0) || (cfg_max_ostd > cnt_t'(N))) ? cnt_t'(N) : cfg_max_ostd;
    end

    assign alloc_ready = (cnt_q < lim);
    assign alloc_idx   = lowest_free(busy_q);
    assign alloc_fire  = alloc_valid & alloc_ready;

    // clr_mask is zero for out-of-range indices, so this also rejects rel_idx >= N.
    // The granted slot is free, so releasing it in the same cycle is never a hit.
    assign rel_hit   = |(busy_q & clr_mask);
    assign rel_legal = rel_valid & rel_hit;

    always_comb begin
        rel_tag = '0;
        for (int i = 0; i < N; i++) begin
            if (clr_mask[i]) begin
                rel_tag = tag_q[i];
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (rel_legal) begin
            busy_d = busy_d & ~clr_mask;
        end
        if (alloc_fire) begin
            busy_d = busy_d | set_mask;
        end

        unique case ({alloc_fire, rel_legal})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (rel_valid & ~rel_hit);

        for (int i = 0; i < N; i++) begin
            tag_d[i] = (alloc_fire && set_mask[i]) ? alloc_tag : tag_q[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign busy_mask    = busy_q;
    assign ostd_cnt     = cnt_q;
    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == lim);
    assign err_rel_idle = err_q;

endmodule

// File: tb/tb_atctlc2axi500_ostd_tracker.sv
// Self-checking bench: directed vector table, reset-in-traffic sequence, randomized run vs model.
module tb_atctlc2axi500_ostd_tracker;

    localparam int N     = 8;
    localparam int TAG_W = 8;
    localparam int W     = 3;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [W:0]       cfg_max_ostd;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic             alloc_ready;
    logic [W-1:0]     alloc_idx;
    logic             rel_valid;
    logic [W-1:0]     rel_idx;
    logic [TAG_W-1:0] rel_tag;
    logic [N-1:0]     busy_mask;
    logic [W:0]       ostd_cnt;
    logic             empty;
    logic             full;
    logic             err_rel_idle;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    atctlc2axi500_ostd_tracker #(.N(N), .TAG_W(TAG_W)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_max_ostd (cfg_max_ostd),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .rel_valid    (rel_valid),
        .rel_idx      (rel_idx),
        .rel_tag      (rel_tag),
        .busy_mask    (busy_mask),
        .ostd_cnt     (ostd_cnt),
        .empty        (empty),
        .full         (full),
        .err_rel_idle (err_rel_idle)
    );

    typedef struct {
        logic [W:0]       cfg;
        logic             av;
        logic [TAG_W-1:0] at;
        logic             rv;
        logic [W-1:0]     ri;
        logic             e_rdy;
        logic [W-1:0]     e_idx;
        logic [N-1:0]     e_busy;
        logic [W:0]       e_cnt;
        logic             e_full;
        logic             e_empty;
        logic             e_err;
        logic [TAG_W-1:0] e_rtag;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input int cfg, input int av, input int at, input int rv,
                                input int ri, input int rdy, input int idx, input int busy,
                                input int cnt, input int fl, input int em, input int er,
                                input int rtag);
        vec_t v;
        v.cfg = (W+1)'(cfg);  v.av = 1'(av);     v.at = TAG_W'(at);
        v.rv = 1'(rv);        v.ri = W'(ri);     v.e_rdy = 1'(rdy);
        v.e_idx = W'(idx);    v.e_busy = N'(busy); v.e_cnt = (W+1)'(cnt);
        v.e_full = 1'(fl);    v.e_empty = 1'(em); v.e_err = 1'(er);
        v.e_rtag = TAG_W'(rtag);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [W:0] cfg, input logic av, input logic [TAG_W-1:0] at,
                         input logic rv, input logic [W-1:0] ri);
        cfg_max_ostd = cfg;
        alloc_valid  = av;
        alloc_tag    = at;
        rel_valid    = rv;
        rel_idx      = ri;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, '0, 1'b0, '0);
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Reference model: slot occupancy as an array, count derived by population.
    bit               m_busy [N];
    logic [TAG_W-1:0] m_tag  [N];
    bit               m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_err = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 'h10, 0, 0, 1, 0, 'h00, 0, 0, 1, 0, 'h00);
        vecs[1]  = mk(0, 1, 'h11, 0, 0, 1, 1, 'h01, 1, 0, 0, 0, 'h00);
        vecs[2]  = mk(0, 1, 'h12, 0, 0, 1, 2, 'h03, 2, 0, 0, 0, 'h00);
        vecs[3]  = mk(0, 1, 'h13, 0, 0, 1, 3, 'h07, 3, 0, 0, 0, 'h00);
        vecs[4]  = mk(0, 1, 'h14, 0, 0, 1, 4, 'h0F, 4, 0, 0, 0, 'h00);
        vecs[5]  = mk(0, 1, 'h15, 0, 0, 1, 5, 'h1F, 5, 0, 0, 0, 'h00);
        vecs[6]  = mk(0, 1, 'h16, 0, 0, 1, 6, 'h3F, 6, 0, 0, 0, 'h00);
        vecs[7]  = mk(0, 1, 'h17, 0, 0, 1, 7, 'h7F, 7, 0, 0, 0, 'h00);
        vecs[8]  = mk(0, 0, 'h00, 1, 3, 0, 0, 'hFF, 8, 1, 0, 0, 'h13);
        vecs[9]  = mk(0, 1, 'h33, 1, 7, 1, 3, 'hF7, 7, 0, 0, 0, 'h17);
        vecs[10] = mk(0, 0, 'h00, 1, 6, 1, 7, 'h7F, 7, 0, 0, 0, 'h16);
        vecs[11] = mk(0, 0, 'h00, 1, 5, 1, 6, 'h3F, 6, 0, 0, 0, 'h15);
        vecs[12] = mk(0, 0, 'h00, 1, 4, 1, 5, 'h1F, 5, 0, 0, 0, 'h14);
        vecs[13] = mk(0, 1, 'hAA, 1, 1, 1, 4, 'h0F, 4, 0, 0, 0, 'h11);
        vecs[14] = mk(0, 0, 'h00, 1, 3, 1, 1, 'h1D, 4, 0, 0, 0, 'h33);
        vecs[15] = mk(0, 0, 'h00, 1, 4, 1, 1, 'h15, 3, 0, 0, 0, 'hAA);
        vecs[16] = mk(2, 0, 'h00, 0, 0, 0, 1, 'h05, 2, 1, 0, 0, 'h00);
        vecs[17] = mk(1, 0, 'h00, 0, 0, 0, 1, 'h05, 2, 0, 0, 0, 'h00);
        vecs[18] = mk(1, 0, 'h00, 1, 0, 0, 1, 'h05, 2, 0, 0, 0, 'h10);
        vecs[19] = mk(1, 0, 'h00, 0, 0, 0, 0, 'h04, 1, 1, 0, 0, 'h00);
        vecs[20] = mk(1, 0, 'h00, 1, 2, 0, 0, 'h04, 1, 1, 0, 0, 'h12);
        vecs[21] = mk(1, 1, 'h55, 0, 0, 1, 0, 'h00, 0, 0, 1, 0, 'h00);
        vecs[22] = mk(0, 0, 'h00, 1, 5, 1, 1, 'h01, 1, 0, 0, 0, 'h15);
        vecs[23] = mk(0, 0, 'h00, 0, 0, 1, 1, 'h01, 1, 0, 0, 1, 'h00);
        vecs[24] = mk(9, 1, 'h66, 1, 1, 1, 1, 'h01, 1, 0, 0, 1, 'h11);
        vecs[25] = mk(9, 0, 'h00, 1, 1, 1, 2, 'h03, 2, 0, 0, 1, 'h66);

        do_reset();

        // Directed table: expectations are the outputs seen during the cycle, before the edge.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].cfg, vecs[i].av, vecs[i].at, vecs[i].rv, vecs[i].ri);
            @(negedge aclk);
            chk($sformatf("v%0d alloc_ready", i), 64'(alloc_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d alloc_idx", i), 64'(alloc_idx), 64'(vecs[i].e_idx));
            chk($sformatf("v%0d busy_mask", i), 64'(busy_mask), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d ostd_cnt", i), 64'(ostd_cnt), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d full", i), 64'(full), 64'(vecs[i].e_full));
            chk($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].e_empty));
            chk($sformatf("v%0d err_rel_idle", i), 64'(err_rel_idle), 64'(vecs[i].e_err));
            if (vecs[i].rv) begin
                chk($sformatf("v%0d rel_tag", i), 64'(rel_tag), 64'(vecs[i].e_rtag));
            end
            @(posedge aclk);
            #1;
        end

        // Reset in the middle of traffic with busy_mask = 0x3C.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive('0, 1'b1, TAG_W'(8'h40 + i), 1'b0, '0);
            @(posedge aclk);
            #1;
        end
        drive('0, 1'b0, '0, 1'b1, 3'd0);
        @(posedge aclk);
        #1 drive('0, 1'b0, '0, 1'b1, 3'd1);
        @(posedge aclk);
        #1 drive('0, 1'b1, 8'h77, 1'b1, 3'd6);
        @(negedge aclk);
        chk("rst pre busy_mask", 64'(busy_mask), 64'h3C);
        chk("rst pre ostd_cnt", 64'(ostd_cnt), 64'd4);
        #2 aresetn = 1'b0;
        #1;
        chk("rst busy_mask", 64'(busy_mask), 64'h00);
        chk("rst empty", 64'(empty), 64'd1);
        chk("rst ostd_cnt", 64'(ostd_cnt), 64'd0);
        chk("rst err", 64'(err_rel_idle), 64'd0);
        chk("rst alloc_ready", 64'(alloc_ready), 64'd1);
        drive('0, 1'b0, '0, 1'b0, '0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        drive('0, 1'b1, 8'h99, 1'b0, '0);
        @(negedge aclk);
        chk("post-rst alloc_idx", 64'(alloc_idx), 64'd0);
        @(posedge aclk);
        #1 drive('0, 1'b0, '0, 1'b1, 3'd0);
        @(negedge aclk);
        chk("post-rst busy_mask", 64'(busy_mask), 64'h01);
        chk("post-rst rel_tag", 64'(rel_tag), 64'h99);

        // Randomized traffic against the reference model.
        do_reset();
        m_reset();
        begin
            logic [W:0] cfg = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                int               lim, cnt, first;
                logic             av, rv, granted, legal;
                logic [TAG_W-1:0] at;
                logic [W-1:0]     ri;
                if (cyc % 50 == 0) cfg = (W+1)'($urandom_range(0, 15));
                av = ($urandom_range(0, 3) != 0);
                rv = ($urandom_range(0, 1) != 0);
                at = TAG_W'($urandom);
                ri = W'($urandom_range(0, N - 1));
                drive(cfg, av, at, rv, ri);

                lim = ((cfg == 0) || (int'(cfg) > N)) ? N : int'(cfg);
                cnt = m_count();
                first = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) first = i;

                @(negedge aclk);
                chk("rnd alloc_ready", 64'(alloc_ready), 64'(cnt < lim));
                chk("rnd alloc_idx", 64'(alloc_idx), 64'((first < 0) ? 0 : first));
                chk("rnd busy_mask", 64'(busy_mask), 64'(m_mask()));
                chk("rnd ostd_cnt", 64'(ostd_cnt), 64'(cnt));
                chk("rnd full", 64'(full), 64'(cnt == lim));
                chk("rnd empty", 64'(empty), 64'(cnt == 0));
                chk("rnd err_rel_idle", 64'(err_rel_idle), 64'(m_err));
                if (rv) chk("rnd rel_tag", 64'(rel_tag), 64'(m_tag[ri]));

                granted = av && (cnt < lim);
                legal   = rv && m_busy[ri];
                if (legal) m_busy[ri] = 1'b0;
                if (granted) begin
                    m_busy[first] = 1'b1;
                    m_tag[first]  = at;
                end
                if (rv && !legal) m_err = 1'b1;

                @(posedge aclk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
